// File: rtl/sseg_io_pkg.sv
// Shared types and constants for the seven-segment IO port.
// Holds the FSM states, the CTRL bit positions, the default addresses and the display transform.
package sseg_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    localparam int CTRL_MODE   = 0;
    localparam int CTRL_FREEZE = 1;
    localparam int CTRL_IMM    = 2;
    localparam int CTRL_SAT    = 3;
    localparam int CTRL_PEND   = 4;

    localparam logic [31:0] DEFAULT_ADDR_VALUE = 32'h1100_4000;
    localparam logic [31:0] DEFAULT_ADDR_CTRL  = 32'h1100_4004;

    localparam logic [15:0] DEC_MAX = 16'd9999;

    // Saturation only applies in decimal mode; hex mode always shows the raw value.
    function automatic logic [15:0] disp(input logic [15:0] v, input logic [3:0] ctrl);
        return (ctrl[CTRL_SAT] && ctrl[CTRL_MODE] && (v > DEC_MAX)) ? DEC_MAX : v;
    endfunction

endpackage

// File: rtl/sseg_io_port_refresh_tick_gen.sv
// Free-running refresh counter; TICK is high for the single cycle the count sits at its last value.
module refresh_tick_gen #(
    parameter int REFRESH_CYCLES = 10_000_000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign TICK = (count == LAST);

endmodule

// File: rtl/sseg_io_port.sv
// IOBUS peripheral holding shadow VALUE/CTRL registers and committing them to the
// seven-segment driver at a bounded refresh rate, with optional decimal saturation.
module sseg_io_port
    import sseg_io_pkg::*;
#(
    parameter logic [31:0] ADDR_VALUE     = DEFAULT_ADDR_VALUE,
    parameter logic [31:0] ADDR_CTRL      = DEFAULT_ADDR_CTRL,
    parameter int          REFRESH_CYCLES = 10_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic [15:0] DATA_OUT,
    output logic        MODE_OUT,
    output logic        UPDATED
);

    logic [15:0] val_sh;
    logic [3:0]  ctrl;
    state_t      state;
    logic        tick;

    logic        wr_value;
    logic        wr_ctrl;
    logic        wr_any;
    logic [3:0]  ctrl_next;
    logic        imm_eff;
    logic        frz_eff;

    // Upper write-data bits carry no register content.
    logic        unused_bus_bits;
    assign unused_bus_bits = ^IOBUS_OUT[31:16];

    refresh_tick_gen #(
        .REFRESH_CYCLES(REFRESH_CYCLES)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .TICK(tick)
    );

    assign wr_value  = IOBUS_WR && (IOBUS_ADDR == ADDR_VALUE);
    assign wr_ctrl   = IOBUS_WR && (IOBUS_ADDR == ADDR_CTRL);
    assign wr_any    = wr_value || wr_ctrl;
    // A CTRL write in this cycle steers the FSM with the value being written.
    assign ctrl_next = wr_ctrl ? IOBUS_OUT[3:0] : ctrl;
    assign imm_eff   = ctrl_next[CTRL_IMM];
    assign frz_eff   = ctrl_next[CTRL_FREEZE];

    always_ff @(posedge CLK) begin
        if (RST) begin
            val_sh <= '0;
            ctrl   <= '0;
        end else begin
            if (wr_value) val_sh <= IOBUS_OUT[15:0];
            if (wr_ctrl)  ctrl   <= IOBUS_OUT[3:0];
        end
    end

    // NOTE: non-blocking assignments make COMMIT capture the pre-edge shadow, so a write in that same cycle is excluded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            DATA_OUT <= '0;
            MODE_OUT <= 1'b0;
            UPDATED  <= 1'b0;
        end else begin
            UPDATED <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_any) state <= imm_eff ? COMMIT : PENDING;
                end
                PENDING: begin
                    if (!frz_eff && (tick || (wr_ctrl && imm_eff))) state <= COMMIT;
                end
                COMMIT: begin
                    DATA_OUT <= disp(val_sh, ctrl);
                    MODE_OUT <= ctrl[CTRL_MODE];
                    UPDATED  <= 1'b1;
                    if (wr_any) state <= imm_eff ? COMMIT : PENDING;
                    else        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RD_DATA <= '0;
        end else if (IOBUS_ADDR == ADDR_VALUE) begin
            RD_DATA <= {16'h0, val_sh};
        end else if (IOBUS_ADDR == ADDR_CTRL) begin
            RD_DATA <= {27'h0, (state == PENDING), ctrl};
        end else begin
            RD_DATA <= '0;
        end
    end

endmodule

// File: tb/tb_sseg_io_port.sv
// Self-checking bench for sseg_io_port: directed scenarios plus a randomized run against a behavioural model.
module tb_sseg_io_port;

    localparam logic [31:0] A_VAL   = 32'h1100_4000;
    localparam logic [31:0] A_CTRL  = 32'h1100_4004;
    localparam logic [31:0] A_OTHER = 32'h1100_4008;
    localparam int          RC      = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT  = '0;
    logic        IOBUS_WR   = 1'b0;
    logic [31:0] RD_DATA;
    logic [15:0] DATA_OUT;
    logic        MODE_OUT;
    logic        UPDATED;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Behavioural model state: what software has written, whether a change is
    // waiting for the refresh rate, and whether the display loads on the next edge.
    logic [15:0] m_val;
    logic [3:0]  m_ctrl;
    int          m_phase;
    logic        m_dirty;
    logic        m_go;
    logic [15:0] m_data;
    logic        m_mode;
    logic        m_upd;
    logic [31:0] m_rd;

    sseg_io_port #(
        .ADDR_VALUE    (A_VAL),
        .ADDR_CTRL     (A_CTRL),
        .REFRESH_CYCLES(RC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IOBUS_ADDR(IOBUS_ADDR),
        .IOBUS_OUT (IOBUS_OUT),
        .IOBUS_WR  (IOBUS_WR),
        .RD_DATA   (RD_DATA),
        .DATA_OUT  (DATA_OUT),
        .MODE_OUT  (MODE_OUT),
        .UPDATED   (UPDATED)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        RST      = 1'b1;
        IOBUS_WR = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        cyc = 0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic wait_update(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (UPDATED === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic model_step();
        logic       tk, wv, wc;
        logic [3:0] nc;
        if (RST) begin
            m_val = '0; m_ctrl = '0; m_phase = 0; m_dirty = 1'b0; m_go = 1'b0;
            m_data = '0; m_mode = 1'b0; m_upd = 1'b0; m_rd = '0;
            return;
        end
        tk = (m_phase == RC - 1);
        wv = IOBUS_WR && (IOBUS_ADDR == A_VAL);
        wc = IOBUS_WR && (IOBUS_ADDR == A_CTRL);
        nc = wc ? IOBUS_OUT[3:0] : m_ctrl;
        if (IOBUS_ADDR == A_VAL)       m_rd = {16'h0, m_val};
        else if (IOBUS_ADDR == A_CTRL) m_rd = {27'h0, m_dirty, m_ctrl};
        else                           m_rd = 32'h0;
        m_upd = m_go;
        if (m_go) begin
            m_mode = m_ctrl[0];
            m_data = (m_ctrl[3] && m_ctrl[0] && m_val > 16'd9999) ? 16'd9999 : m_val;
        end
        if (m_go || !m_dirty) begin
            m_go    = (wv || wc) && nc[2];
            m_dirty = (wv || wc) && !nc[2];
        end else if (!nc[1] && (tk || (wc && nc[2]))) begin
            m_go    = 1'b1;
            m_dirty = 1'b0;
        end
        if (wv) m_val = IOBUS_OUT[15:0];
        m_ctrl  = nc;
        m_phase = (m_phase + 1) % RC;
    endtask

    task automatic test_reset();
        bit seen;
        release_reset();
        bus_wr(A_CTRL, 32'h4);
        bus_wr(A_VAL, 32'hABCD);
        step();
        vectors++;
        if (DATA_OUT !== 16'hABCD) begin
            miscompares++;
            $display("FAIL reset_preload: data=%h expected abcd", DATA_OUT);
        end
        repeat (2) step();
        RST = 1'b1;
        IOBUS_ADDR = A_VAL;
        repeat (2) step();
        vectors++;
        if (DATA_OUT !== 16'h0 || MODE_OUT !== 1'b0 || UPDATED !== 1'b0 || RD_DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: data=%h mode=%b upd=%b rd=%h expected all zero",
                     DATA_OUT, MODE_OUT, UPDATED, RD_DATA);
        end
        RST = 1'b0;
        cyc = 0;
        step();
        vectors++;
        if (RD_DATA !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_value_reg: rd=%h expected 00000000", RD_DATA);
        end
        bus_wr(A_VAL, 32'h0777);
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 9 || DATA_OUT !== 16'h0777) begin
            miscompares++;
            $display("FAIL reset_first_tick: seen=%b edge=%0d data=%h expected edge 9 data 0777",
                     seen, cyc, DATA_OUT);
        end
    endtask

    task automatic test_rate_limit();
        release_reset();
        repeat (2) step();
        bus_wr(A_VAL, 32'h1234);
        IOBUS_ADDR = A_CTRL;
        while (cyc < 9) begin
            vectors++;
            if (DATA_OUT !== 16'h0 || UPDATED !== 1'b0) begin
                miscompares++;
                $display("FAIL rate_hold edge=%0d: data=%h upd=%b expected 0000/0", cyc, DATA_OUT, UPDATED);
            end
            if (cyc == 5) begin
                vectors++;
                if (RD_DATA !== 32'h10) begin
                    miscompares++;
                    $display("FAIL rate_pending_flag: rd=%h expected 00000010", RD_DATA);
                end
            end
            step();
        end
        vectors++;
        if (DATA_OUT !== 16'h1234 || UPDATED !== 1'b1) begin
            miscompares++;
            $display("FAIL rate_commit: data=%h upd=%b expected 1234/1", DATA_OUT, UPDATED);
        end
        step();
        vectors++;
        if (UPDATED !== 1'b0 || DATA_OUT !== 16'h1234) begin
            miscompares++;
            $display("FAIL rate_single_pulse: data=%h upd=%b expected 1234/0", DATA_OUT, UPDATED);
        end
    endtask

    task automatic test_imm();
        logic [15:0] prev, nv;
        release_reset();
        bus_wr(A_CTRL, 32'h4);
        prev = 16'h0;
        for (int k = 0; k < 4; k++) begin
            nv = (k == 0) ? 16'hBEEF : 16'($urandom);
            repeat ($urandom_range(0, 9)) step();
            bus_wr(A_VAL, {16'h0, nv});
            vectors++;
            if (DATA_OUT !== prev) begin
                miscompares++;
                $display("FAIL imm_early: data=%h expected %h", DATA_OUT, prev);
            end
            step();
            vectors++;
            if (DATA_OUT !== nv || UPDATED !== 1'b1) begin
                miscompares++;
                $display("FAIL imm_latency: data=%h upd=%b expected %h/1", DATA_OUT, UPDATED, nv);
            end
            prev = nv;
        end
    endtask

    task automatic test_freeze();
        bit seen;
        release_reset();
        bus_wr(A_CTRL, 32'h2);
        bus_wr(A_VAL, 32'h0042);
        IOBUS_ADDR = A_CTRL;
        while (cyc < 26) begin
            step();
            vectors++;
            if (DATA_OUT !== 16'h0 || UPDATED !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_hold edge=%0d: data=%h upd=%b expected 0000/0", cyc, DATA_OUT, UPDATED);
            end
        end
        vectors++;
        if (RD_DATA !== 32'h12) begin
            miscompares++;
            $display("FAIL freeze_ctrl_read: rd=%h expected 00000012", RD_DATA);
        end
        bus_wr(A_CTRL, 32'h0);
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 33 || DATA_OUT !== 16'h0042 || MODE_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL freeze_release: seen=%b edge=%0d data=%h mode=%b expected edge 33 0042/0",
                     seen, cyc, DATA_OUT, MODE_OUT);
        end
    endtask

    task automatic test_saturation();
        bit seen;
        release_reset();
        bus_wr(A_CTRL, 32'h9);
        bus_wr(A_VAL, 32'd12345);
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 9 || DATA_OUT !== 16'h270F || MODE_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_clamp: seen=%b edge=%0d data=%h mode=%b expected edge 9 270f/1",
                     seen, cyc, DATA_OUT, MODE_OUT);
        end
        bus_wr(A_CTRL, 32'h1);
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 17 || DATA_OUT !== 16'h3039 || MODE_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_off: seen=%b edge=%0d data=%h mode=%b expected edge 17 3039/1",
                     seen, cyc, DATA_OUT, MODE_OUT);
        end
        bus_wr(A_CTRL, 32'hD);
        bus_wr(A_VAL, 32'd10000);
        step();
        vectors++;
        if (DATA_OUT !== 16'h270F || MODE_OUT !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_boundary: data=%h mode=%b expected 270f/1", DATA_OUT, MODE_OUT);
        end
        bus_wr(A_CTRL, 32'hC);
        step();
        vectors++;
        if (DATA_OUT !== 16'h2710 || MODE_OUT !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_hex_mode: data=%h mode=%b expected 2710/0", DATA_OUT, MODE_OUT);
        end
    endtask

    task automatic test_collision();
        bit seen;
        release_reset();
        bus_wr(A_VAL, 32'h1111);
        while (cyc < 8) step();
        bus_wr(A_VAL, 32'h2222);
        vectors++;
        if (DATA_OUT !== 16'h1111 || UPDATED !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_commit_old: data=%h upd=%b expected 1111/1", DATA_OUT, UPDATED);
        end
        IOBUS_ADDR = A_CTRL;
        step();
        vectors++;
        if (RD_DATA !== 32'h10) begin
            miscompares++;
            $display("FAIL coll_rearm: rd=%h expected 00000010", RD_DATA);
        end
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 17 || DATA_OUT !== 16'h2222) begin
            miscompares++;
            $display("FAIL coll_new_value: seen=%b edge=%0d data=%h expected edge 17 2222", seen, cyc, DATA_OUT);
        end
        while (cyc < 23) step();
        bus_wr(A_VAL, 32'h3333);
        wait_update(20, seen);
        vectors++;
        if (!seen || cyc != 33 || DATA_OUT !== 16'h3333) begin
            miscompares++;
            $display("FAIL coll_tick_write: seen=%b edge=%0d data=%h expected edge 33 3333", seen, cyc, DATA_OUT);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int          sel;
        release_reset();
        RST = 1'b1;
        model_step();
        RST = 1'b0;
        for (int n = 0; n < 600; n++) begin
            RST = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 2);
            IOBUS_ADDR = (sel == 0) ? A_VAL : (sel == 1) ? A_CTRL : A_OTHER;
            IOBUS_WR   = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (sel == 0 && $urandom_range(0, 1) == 0) d = 32'($urandom_range(9990, 10010));
            if (sel == 1 && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            IOBUS_OUT = d;
            model_step();
            step();
            vectors++;
            if (DATA_OUT !== m_data || MODE_OUT !== m_mode || UPDATED !== m_upd || RD_DATA !== m_rd) begin
                miscompares++;
                $display("FAIL random n=%0d: data=%h mode=%b upd=%b rd=%h expected %h/%b/%b/%h",
                         n, DATA_OUT, MODE_OUT, UPDATED, RD_DATA, m_data, m_mode, m_upd, m_rd);
            end
        end
        RST      = 1'b0;
        IOBUS_WR = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rate_limit();
        test_imm();
        test_freeze();
        test_saturation();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
